// File: rtl/mips_pkg.sv
// Shared encodings for the control pipeline: forward selects and the bubble.
// Used by ctrl_pipeline and hazard_detect.
package mips_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_t;

    typedef struct packed {
        logic mem2reg;
        logic mem_wr;
        logic branch;
        logic alu_src;
        logic reg_dst;
        logic reg_wr;
        logic jmp;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Stall and forward-select generation for the E stage.
// CTRL_PIPELINE_FORWARD_EN selects forwarding with load-use stalls only.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int WIDTH_REG_ADDR = 5
) (
    input  logic [WIDTH_REG_ADDR-1:0] rs_d,
    input  logic [WIDTH_REG_ADDR-1:0] rt_d,
    input  logic [WIDTH_REG_ADDR-1:0] rs_e,
    input  logic [WIDTH_REG_ADDR-1:0] rt_e,
    input  logic [WIDTH_REG_ADDR-1:0] wr_reg_e,
    input  logic [WIDTH_REG_ADDR-1:0] wr_reg_m,
    input  logic [WIDTH_REG_ADDR-1:0] wr_reg_w,
    input  logic                      reg_wr_e,
    input  logic                      mem2reg_e,
    input  logic                      reg_wr_m,
    input  logic                      reg_wr_w,
    output logic                      stall,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e
);

    localparam int RW = WIDTH_REG_ADDR;

    function automatic logic hit(
        input logic [RW-1:0] src,
        input logic [RW-1:0] wr,
        input logic          we
    );
        return we && (src != '0) && (src == wr);
    endfunction

    logic match_e;
    logic match_m;

    assign match_e = hit(rs_d, wr_reg_e, reg_wr_e)
                   | hit(rt_d, wr_reg_e, reg_wr_e);
    assign match_m = hit(rs_d, wr_reg_m, reg_wr_m)
                   | hit(rt_d, wr_reg_m, reg_wr_m);

`ifdef CTRL_PIPELINE_FORWARD_EN
    // M is newer than W, so it wins when both hold the same register
    function automatic logic [1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic [RW-1:0] wm,
        input logic          we_m,
        input logic [RW-1:0] ww,
        input logic          we_w
    );
        if (hit(src, wm, we_m))
            return FWD_M;
        else if (hit(src, ww, we_w))
            return FWD_W;
        else
            return FWD_REG;
    endfunction

    assign stall       = mem2reg_e & match_e;
    assign forward_a_e = fwd_sel(rs_e, wr_reg_m, reg_wr_m,
                                 wr_reg_w, reg_wr_w);
    assign forward_b_e = fwd_sel(rt_e, wr_reg_m, reg_wr_m,
                                 wr_reg_w, reg_wr_w);

    logic unused;
    assign unused = match_m;
`else
    // W needs no check: the register file writes before it reads
    assign stall       = match_e | match_m;
    assign forward_a_e = FWD_REG;
    assign forward_b_e = FWD_REG;

    logic unused;
    assign unused = ^{mem2reg_e, rs_e, rt_e, wr_reg_w, reg_wr_w};
`endif

endmodule

// File: rtl/ctrl_pipeline.sv
// E/M/W control pipeline registers with stall, flush and forwarding.
// Define CTRL_PIPELINE_FORWARD_EN to enable forwarding.
module ctrl_pipeline
    import mips_pkg::*;
#(
    parameter int WIDTH_ALU_CONTROL = 3,
    parameter int WIDTH_REG_ADDR    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_ALU_CONTROL-1:0] alu_control_d,
    input  logic                         mem2reg_d,
    input  logic                         mem_wr_d,
    input  logic                         branch_d,
    input  logic                         alu_src_d,
    input  logic                         reg_dst_d,
    input  logic                         reg_wr_d,
    input  logic                         jmp_d,
    input  logic [WIDTH_REG_ADDR-1:0]    rs_d,
    input  logic [WIDTH_REG_ADDR-1:0]    rt_d,
    input  logic [WIDTH_REG_ADDR-1:0]    rd_d,
    input  logic                         redirect_e,
    output logic [WIDTH_ALU_CONTROL-1:0] alu_control_e,
    output logic                         alu_src_e,
    output logic                         reg_dst_e,
    output logic                         branch_e,
    output logic                         jmp_e,
    output logic [WIDTH_REG_ADDR-1:0]    rs_e,
    output logic [WIDTH_REG_ADDR-1:0]    rt_e,
    output logic                         mem2reg_m,
    output logic                         mem_wr_m,
    output logic                         reg_wr_m,
    output logic                         mem2reg_w,
    output logic                         reg_wr_w,
    output logic [WIDTH_REG_ADDR-1:0]    wr_reg_e,
    output logic [WIDTH_REG_ADDR-1:0]    wr_reg_m,
    output logic [WIDTH_REG_ADDR-1:0]    wr_reg_w,
    output logic                         stall_f,
    output logic                         stall_d,
    output logic                         flush_d,
    output logic [1:0]                   forward_a_e,
    output logic [1:0]                   forward_b_e
);

    localparam int RW = WIDTH_REG_ADDR;

    ctrl_t         ctrl_d;
    ctrl_t         ctrl_e;
    logic [RW-1:0] rd_e;
    logic          stall_hd;
    logic          bubble_e;
    logic          stall;

    assign ctrl_d = '{
        mem2reg: mem2reg_d,
        mem_wr:  mem_wr_d,
        branch:  branch_d,
        alu_src: alu_src_d,
        reg_dst: reg_dst_d,
        reg_wr:  reg_wr_d,
        jmp:     jmp_d
    };

    // Redirect wins: the D instruction is discarded, so holding it is moot
    assign stall    = stall_hd & ~redirect_e & ~rst;
    assign stall_f  = stall;
    assign stall_d  = stall;
    assign flush_d  = redirect_e & ~rst;
    assign bubble_e = stall_hd | redirect_e;

    assign alu_src_e = ctrl_e.alu_src;
    assign reg_dst_e = ctrl_e.reg_dst;
    assign branch_e  = ctrl_e.branch;
    assign jmp_e     = ctrl_e.jmp;
    assign wr_reg_e  = ctrl_e.reg_dst ? rd_e : rt_e;

    always_ff @(posedge clk) begin
        if (rst || bubble_e) begin
            ctrl_e        <= BUBBLE;
            alu_control_e <= '0;
            rs_e          <= '0;
            rt_e          <= '0;
            rd_e          <= '0;
        end else begin
            ctrl_e        <= ctrl_d;
            alu_control_e <= alu_control_d;
            rs_e          <= rs_d;
            rt_e          <= rt_d;
            rd_e          <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem2reg_m <= 1'b0;
            mem_wr_m  <= 1'b0;
            reg_wr_m  <= 1'b0;
            wr_reg_m  <= '0;
            mem2reg_w <= 1'b0;
            reg_wr_w  <= 1'b0;
            wr_reg_w  <= '0;
        end else begin
            mem2reg_m <= ctrl_e.mem2reg;
            mem_wr_m  <= ctrl_e.mem_wr;
            reg_wr_m  <= ctrl_e.reg_wr;
            wr_reg_m  <= wr_reg_e;
            mem2reg_w <= mem2reg_m;
            reg_wr_w  <= reg_wr_m;
            wr_reg_w  <= wr_reg_m;
        end
    end

    hazard_detect #(
        .WIDTH_REG_ADDR(RW)
    ) u_hazard (
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .rs_e       (rs_e),
        .rt_e       (rt_e),
        .wr_reg_e   (wr_reg_e),
        .wr_reg_m   (wr_reg_m),
        .wr_reg_w   (wr_reg_w),
        .reg_wr_e   (ctrl_e.reg_wr),
        .mem2reg_e  (ctrl_e.mem2reg),
        .reg_wr_m   (reg_wr_m),
        .reg_wr_w   (reg_wr_w),
        .stall      (stall_hd),
        .forward_a_e(forward_a_e),
        .forward_b_e(forward_b_e)
    );

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Randomized and directed check of ctrl_pipeline against an instruction-level model.
// Build with CTRL_PIPELINE_FORWARD_EN defined to check the forwarding variant.
module tb_ctrl_pipeline;

    localparam int AW = 3;
    localparam int RW = 5;
`ifdef CTRL_PIPELINE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] alu_control_d;
    logic          mem2reg_d, mem_wr_d, branch_d, alu_src_d;
    logic          reg_dst_d, reg_wr_d, jmp_d;
    logic [RW-1:0] rs_d, rt_d, rd_d;
    logic          redirect_e;
    logic [AW-1:0] alu_control_e;
    logic          alu_src_e, reg_dst_e, branch_e, jmp_e;
    logic [RW-1:0] rs_e, rt_e;
    logic          mem2reg_m, mem_wr_m, reg_wr_m, mem2reg_w, reg_wr_w;
    logic [RW-1:0] wr_reg_e, wr_reg_m, wr_reg_w;
    logic          stall_f, stall_d, flush_d;
    logic [1:0]    forward_a_e, forward_b_e;

    always #5 clk = ~clk;

    ctrl_pipeline #(
        .WIDTH_ALU_CONTROL(AW),
        .WIDTH_REG_ADDR(RW)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_control_d(alu_control_d), .mem2reg_d(mem2reg_d),
        .mem_wr_d(mem_wr_d), .branch_d(branch_d), .alu_src_d(alu_src_d),
        .reg_dst_d(reg_dst_d), .reg_wr_d(reg_wr_d), .jmp_d(jmp_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .redirect_e(redirect_e),
        .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
        .reg_dst_e(reg_dst_e), .branch_e(branch_e), .jmp_e(jmp_e),
        .rs_e(rs_e), .rt_e(rt_e),
        .mem2reg_m(mem2reg_m), .mem_wr_m(mem_wr_m), .reg_wr_m(reg_wr_m),
        .mem2reg_w(mem2reg_w), .reg_wr_w(reg_wr_w),
        .wr_reg_e(wr_reg_e), .wr_reg_m(wr_reg_m), .wr_reg_w(wr_reg_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
    );

    typedef struct {
        logic [AW-1:0] alu;
        logic mem2reg, mem_wr, branch, alu_src, reg_dst, reg_wr, jmp;
        logic [RW-1:0] rs, rt, rd;
    } ins_t;

    // One in-flight instruction; known=0 means its register fields are don't-care
    typedef struct {
        ins_t          i;
        logic [RW-1:0] wr;
        bit            known;
    } stg_t;

    stg_t me, mm, mw;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic stg_t bubble(input bit known);
        stg_t s;
        s.i     = '{default: '0};
        s.wr    = '0;
        s.known = known;
        return s;
    endfunction

    function automatic ins_t mk(input bit we, input bit dst, input bit ld,
                                input int rs, input int rt, input int rd);
        ins_t d;
        d         = '{default: '0};
        d.alu     = 3'd2;
        d.reg_wr  = we;
        d.reg_dst = dst;
        d.mem2reg = ld;
        d.alu_src = ld;
        d.rs      = RW'(rs);
        d.rt      = RW'(rt);
        d.rd      = RW'(rd);
        return d;
    endfunction

    function automatic ins_t rand_ins();
        ins_t d;
        d.alu     = AW'($urandom);
        d.mem2reg = 1'($urandom);
        d.mem_wr  = 1'($urandom);
        d.branch  = 1'($urandom);
        d.alu_src = 1'($urandom);
        d.reg_dst = 1'($urandom);
        d.reg_wr  = ($urandom_range(0, 3) != 0);
        d.jmp     = 1'($urandom);
        d.rs      = RW'($urandom_range(0, 3));
        d.rt      = RW'($urandom_range(0, 3));
        d.rd      = RW'($urandom_range(0, 3));
        return d;
    endfunction

    function automatic bit hit(input stg_t s, input logic [RW-1:0] a);
        return s.i.reg_wr && (a != 0) && (a == s.wr);
    endfunction

    function automatic bit need_stall(input ins_t d);
        if (FWD)
            return me.i.mem2reg && (hit(me, d.rs) || hit(me, d.rt));
        return hit(me, d.rs) || hit(me, d.rt) || hit(mm, d.rs) || hit(mm, d.rt);
    endfunction

    function automatic logic [1:0] fwd_of(input logic [RW-1:0] a);
        logic [1:0] r;
        r = hit(mm, a) ? 2'b10 : hit(mw, a) ? 2'b01 : 2'b00;
        return FWD ? r : 2'b00;
    endfunction

    task automatic step(input ins_t d, input bit r, input bit redir,
                        output bit st);
        bit raw;
        @(negedge clk);
        rst = r; redirect_e = redir;
        alu_control_d = d.alu; mem2reg_d = d.mem2reg; mem_wr_d = d.mem_wr;
        branch_d = d.branch; alu_src_d = d.alu_src; reg_dst_d = d.reg_dst;
        reg_wr_d = d.reg_wr; jmp_d = d.jmp;
        rs_d = d.rs; rt_d = d.rt; rd_d = d.rd;
        #1;
        raw = need_stall(d);
        st  = raw && !redir && !r;
        chk("stall_f", 32'(stall_f), 32'(st));
        chk("stall_d", 32'(stall_d), 32'(st));
        chk("flush_d", 32'(flush_d), 32'(redir && !r));
        chk("alu_control_e", 32'(alu_control_e), 32'(me.i.alu));
        chk("e_ctrl", {alu_src_e, reg_dst_e, branch_e, jmp_e},
            {me.i.alu_src, me.i.reg_dst, me.i.branch, me.i.jmp});
        if (me.known || !FWD) begin
            chk("forward_a_e", 32'(forward_a_e), 32'(fwd_of(me.i.rs)));
            chk("forward_b_e", 32'(forward_b_e), 32'(fwd_of(me.i.rt)));
        end
        if (me.known) begin
            chk("rs_e", 32'(rs_e), 32'(me.i.rs));
            chk("rt_e", 32'(rt_e), 32'(me.i.rt));
            chk("wr_reg_e", 32'(wr_reg_e), 32'(me.wr));
        end
        chk("m_ctrl", {mem2reg_m, mem_wr_m, reg_wr_m},
            {mm.i.mem2reg, mm.i.mem_wr, mm.i.reg_wr});
        if (mm.known) chk("wr_reg_m", 32'(wr_reg_m), 32'(mm.wr));
        chk("w_ctrl", {mem2reg_w, reg_wr_w}, {mw.i.mem2reg, mw.i.reg_wr});
        if (mw.known) chk("wr_reg_w", 32'(wr_reg_w), 32'(mw.wr));
        @(posedge clk);
        if (r) begin
            me = bubble(1); mm = bubble(1); mw = bubble(1);
        end else begin
            mw = mm;
            mm = me;
            if (raw || redir) begin
                me = bubble(0);
            end else begin
                me.i     = d;
                me.wr    = d.reg_dst ? d.rd : d.rt;
                me.known = 1;
            end
        end
    endtask

    initial begin
        ins_t nop, d;
        bit   st, held;
        nop  = mk(0, 0, 0, 0, 0, 0);
        rst  = 1'b1; redirect_e = 1'b0;
        alu_control_d = '0; mem2reg_d = 0; mem_wr_d = 0; branch_d = 0;
        alu_src_d = 0; reg_dst_d = 0; reg_wr_d = 0; jmp_d = 0;
        rs_d = '0; rt_d = '0; rd_d = '0;
        repeat (2) @(posedge clk);
        me = bubble(1); mm = bubble(1); mw = bubble(1);
        step(nop, 1, 0, st);
        step(nop, 0, 0, st);

        // add r8 then sub reading r8; D is held while stalled
        step(mk(1, 1, 0, 1, 2, 8), 0, 0, st);
        d = mk(1, 1, 0, 8, 3, 10);
        for (int k = 0; k < 4; k++) begin
            step(d, 0, 0, st);
            if (!st) break;
        end
        repeat (3) step(nop, 0, 0, st);

        // lw r9 then a reader of rt=r9
        step(mk(1, 0, 1, 1, 9, 0), 0, 0, st);
        d = mk(1, 1, 0, 4, 9, 11);
        for (int k = 0; k < 4; k++) begin
            step(d, 0, 0, st);
            if (!st) break;
        end
        repeat (3) step(nop, 0, 0, st);

        // redirect together with a load-use match
        step(mk(1, 1, 0, 1, 2, 5), 0, 0, st);
        step(mk(1, 0, 1, 1, 9, 0), 0, 0, st);
        step(mk(1, 1, 0, 9, 9, 12), 0, 1, st);
        repeat (3) step(nop, 0, 0, st);

        // write r0 then read r0
        step(mk(1, 1, 0, 1, 2, 0), 0, 0, st);
        step(mk(1, 1, 0, 0, 0, 6), 0, 0, st);
        repeat (3) step(nop, 0, 0, st);

        // reset while a stall is pending
        step(mk(1, 0, 1, 1, 7, 0), 0, 0, st);
        step(mk(1, 1, 0, 7, 7, 3), 1, 0, st);
        step(mk(1, 1, 0, 7, 7, 3), 0, 0, st);
        repeat (3) step(nop, 0, 0, st);

        held = 0;
        d    = nop;
        for (int n = 0; n < 1500; n++) begin
            if (!held) d = rand_ins();
            step(d, ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 7) == 0), st);
            held = st;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
